// File: rtl/adc_scan_tx_pkg.sv
// Shared types and constants for the ADC scan sequencer.
package adc_scan_pkg;

    // Scan sequencer states
    typedef enum logic [3:0] {
        S_IDLE,
        S_TX_HDR,
        S_W_HDR,
        S_NEXT_CH,
        S_CONV,
        S_W_CONV,
        S_TX_MSB,
        S_W_MSB,
        S_TX_LSB,
        S_W_LSB,
        S_TX_CHK,
        S_W_CHK,
        S_DONE
    } state_t;

    localparam logic [7:0] HDR_DEFAULT     = 8'hA5;
    localparam logic [3:0] CMD_LOW_DEFAULT = 4'b0111;

    // ADC control byte layout
    localparam int unsigned CMD_START_BIT = 7;
    localparam int unsigned CMD_ADDR_MSB  = 6;
    localparam int unsigned CMD_ADDR_LSB  = 4;

    // Build the ADC control byte for a channel address
    function automatic logic [7:0] make_cmd(input logic [2:0] addr, input logic [3:0] low);
        logic [7:0] c;
        c = {4'b0000, low};
        c[CMD_START_BIT] = 1'b1;
        c[CMD_ADDR_MSB:CMD_ADDR_LSB] = addr;
        return c;
    endfunction

endpackage

// File: rtl/adc_scan_tx_if.sv
// SPI-engine and UART-transmitter handshakes seen from the scan sequencer.
interface adc_scan_tx_if #(
    parameter int unsigned DW = 12
);
    logic          strc_o;
    logic [7:0]    cmd_o;
    logic          eoc_i;
    logic [DW-1:0] dout_i;
    logic          st_o;
    logic [7:0]    data_o;
    logic          eot_i;

    modport master (
        output strc_o, cmd_o, st_o, data_o,
        input  eoc_i, dout_i, eot_i
    );

    modport slave (
        input  strc_o, cmd_o, st_o, data_o,
        output eoc_i, dout_i, eot_i
    );
endinterface

// File: rtl/adc_scan_tx_timer.sv
// Period counter for continuous scanning: cleared on trigger, saturating.
module scan_period_timer #(
    parameter int unsigned PW = 29
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clr,
    input  logic [PW-1:0] i_period,
    output logic          o_due
);
    logic [PW-1:0] r_cnt;

    // Count cycles since the last accepted trigger, parking at all-ones
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + PW'(1);
        end
    end

    assign o_due = (r_cnt >= i_period);

endmodule

// File: rtl/adc_scan_tx.sv
// Multi-channel ADC scan sequencer streaming one framed packet per scan:
// header, {ch, result[11:8]} / result[7:0] per enabled channel, XOR checksum.
module adc_scan_tx
    import adc_scan_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned DW      = 12,
    parameter int unsigned PW      = 29,
    parameter logic [3:0]  CMD_LOW = CMD_LOW_DEFAULT,
    parameter logic [7:0]  HDR     = HDR_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic [PW-1:0]     period_i,
    input  logic [NUM_CH-1:0] ch_en_i,
    adc_scan_tx_if.master     bus,
    output logic              busy_o,
    output logic              eos_o,
    output logic              ovr_o
);
    localparam int unsigned   CW     = $clog2(NUM_CH + 1);
    localparam logic [CW-1:0] CH_END = CW'(NUM_CH);

    state_t            r_state;
    state_t            w_next;
    logic [NUM_CH-1:0] r_en_q;
    logic [CW-1:0]     r_ch;
    logic [7:0]        r_lsb;
    logic [7:0]        r_chk;
    logic [7:0]        r_cmd;
    logic [7:0]        r_data;
    logic              r_ovr;

    logic              w_due;
    logic              w_trig;
    logic              w_ch_en;
    logic              w_st;
    logic              w_strc;
    logic              w_eos;
    logic              w_busy;
    logic [NUM_CH-1:0] w_en_sh;
    logic [3:0]        w_ch4;
    logic [11:0]       w_dout12;

    assign w_ch4    = 4'(r_ch);
    assign w_dout12 = 12'(bus.dout_i);
    assign w_en_sh  = r_en_q >> r_ch;
    assign w_ch_en  = w_en_sh[0];
    assign w_trig   = (r_state == S_IDLE) && (start_i || (mode_i && w_due));

    scan_period_timer #(
        .PW(PW)
    ) u_timer (
        .i_clk    (clk_i),
        .i_rst_n  (rst_i),
        .i_clr    (w_trig),
        .i_period (period_i),
        .o_due    (w_due)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_trig) w_next = S_TX_HDR;
            S_TX_HDR:  w_next = S_W_HDR;
            S_W_HDR:   if (bus.eot_i) w_next = S_NEXT_CH;
            S_NEXT_CH: begin
                if (r_ch == CH_END) begin
                    w_next = S_TX_CHK;
                end else if (w_ch_en) begin
                    w_next = S_CONV;
                end
            end
            S_CONV:    w_next = S_W_CONV;
            S_W_CONV:  if (bus.eoc_i) w_next = S_TX_MSB;
            S_TX_MSB:  w_next = S_W_MSB;
            S_W_MSB:   if (bus.eot_i) w_next = S_TX_LSB;
            S_TX_LSB:  w_next = S_W_LSB;
            S_W_LSB:   if (bus.eot_i) w_next = S_NEXT_CH;
            S_TX_CHK:  w_next = S_W_CHK;
            S_W_CHK:   if (bus.eot_i) w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Per-state strobes
    always_comb begin
        w_st   = 1'b0;
        w_strc = 1'b0;
        w_eos  = 1'b0;
        w_busy = (r_state != S_IDLE);
        case (r_state)
            S_TX_HDR, S_TX_MSB, S_TX_LSB, S_TX_CHK: w_st = 1'b1;
            S_CONV:  w_strc = 1'b1;
            S_DONE:  w_eos  = 1'b1;
            default: ;
        endcase
    end

    // Frame datapath: byte/command registers are loaded on the transition
    // into their TX/CONV state so they stay stable through the wait state
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_en_q <= '0;
            r_ch   <= '0;
            r_lsb  <= '0;
            r_chk  <= '0;
            r_cmd  <= '0;
            r_data <= '0;
        end else begin
            if (w_trig) begin
                r_en_q <= ch_en_i;
                r_ch   <= '0;
                r_chk  <= '0;
                r_data <= HDR;
            end
            case (r_state)
                S_NEXT_CH: begin
                    if (r_ch == CH_END) begin
                        r_data <= r_chk;
                    end else if (w_ch_en) begin
                        r_cmd <= make_cmd(w_ch4[2:0], CMD_LOW);
                    end else begin
                        r_ch <= r_ch + CW'(1);
                    end
                end
                S_W_CONV: begin
                    if (bus.eoc_i) begin
                        r_lsb  <= w_dout12[7:0];
                        r_data <= {w_ch4, w_dout12[11:8]};
                    end
                end
                S_TX_MSB:  r_chk <= r_chk ^ r_data;
                S_W_MSB:   if (bus.eot_i) r_data <= r_lsb;
                S_TX_LSB:  r_chk <= r_chk ^ r_data;
                S_W_LSB:   if (bus.eot_i) r_ch <= r_ch + CW'(1);
                default: ;
            endcase
        end
    end

    // Sticky flag for a start request arriving while a scan is in progress
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ovr <= 1'b0;
        end else if (start_i && (r_state != S_IDLE)) begin
            r_ovr <= 1'b1;
        end
    end

    assign bus.strc_o = w_strc;
    assign bus.cmd_o  = r_cmd;
    assign bus.st_o   = w_st;
    assign bus.data_o = r_data;
    assign busy_o     = w_busy;
    assign eos_o      = w_eos;
    assign ovr_o      = r_ovr;

endmodule

// File: doc/adc_scan_tx.md
Name: adc_scan_tx

Overview:
Multi-channel scan sequencer for the ADC-to-UART data path. It replaces the fixed one-channel, two-byte flow.
- On a trigger (single pulse, or the internal periodic timer), it converts every enabled channel through the SPI engine.
- It streams one framed packet through the RS-232 transmitter: header, two bytes per channel, XOR checksum.
- It sits between `single_tick`/top-level controls and the existing `spi_wr` and `rs232_tx` engines, using their strc/eoc and st/eot handshakes.

Parameters:
- NUM_CH, 4, number of ADC channels scanned (1..8).
- DW, 12, ADC result width (9..12). Upper bits are zero-padded into the MSB byte.
- PW, 29, width of the period counter and `period_i`.
- CMD_LOW, 4'b0111, low nibble of the ADC control byte (mode, SGL/DIF, PD1..PD0).
- HDR, 8'hA5, frame header byte.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  single-cycle scan request (from `single_tick`).
- mode_i  in  1  0 = single-shot, 1 = continuous periodic.
- period_i  in  PW  continuous-mode scan period minus one, in clk cycles.
- ch_en_i  in  NUM_CH  channel enable mask.
- strc_o  out  1  one-cycle SPI conversion start.
- cmd_o  out  8  ADC control byte, held from strc_o until eoc_i.
- eoc_i  in  1  one-cycle end-of-conversion from SPI engine.
- dout_i  in  DW  conversion result, valid with eoc_i.
- st_o  out  1  one-cycle UART byte start.
- data_o  out  8  byte to transmit, held from st_o until eot_i.
- eot_i  in  1  one-cycle end-of-transmit from UART.
- busy_o  out  1  high whenever state is not IDLE.
- eos_o  out  1  one-cycle end-of-scan pulse.
- ovr_o  out  1  sticky: a trigger was lost while busy.

Behaviour:
- Reset (`rst_i` = 0, async): state IDLE, all outputs 0, `cmd_o` = 8'h00, `data_o` = 8'h00, period counter 0, `ovr_o` 0, checksum 0.
- Trigger (only in IDLE):
  - `start_i` = 1, or
  - `mode_i` = 1 and period counter ≥ `period_i`.
- Period counter:
  - Clears to 0 on every trigger acceptance.
  - Otherwise increments every cycle, saturating at all-ones.
  - Continuous scan interval = max(period_i+1, scan duration) cycles.
- `start_i` while busy: ignored and sets `ovr_o`. `ovr_o` clears only on reset.
- On trigger, the block latches `ch_en_i` into `en_q`, sets channel index to 0 and clears the checksum. Changes to `ch_en_i` mid-scan have no effect.
- FSM states: IDLE, TX_HDR, W_HDR, NEXT_CH, CONV, W_CONV, TX_MSB, W_MSB, TX_LSB, W_LSB, TX_CHK, W_CHK, DONE.
- Transitions:
  - IDLE → TX_HDR on trigger.
  - TX_HDR: `st_o` = 1 for one cycle, `data_o` = HDR → W_HDR.
  - W_HDR → NEXT_CH on `eot_i`.
  - NEXT_CH:
    - Skip disabled channels, one cycle per index.
    - Enabled index → CONV.
    - Index == NUM_CH → TX_CHK.
  - CONV: `strc_o` = 1 for one cycle, `cmd_o` = {1'b1, ch[2:0], CMD_LOW} → W_CONV.
  - W_CONV: on `eoc_i`, capture `dout_i` → TX_MSB.
  - TX_MSB: `data_o` = {ch[3:0], zero-extended result[11:8]}, `st_o` pulse → W_MSB. Then on `eot_i` → TX_LSB.
  - TX_LSB: `data_o` = result[7:0], `st_o` pulse → W_LSB. Then on `eot_i`, increment index → NEXT_CH.
  - TX_CHK: `data_o` = checksum, `st_o` pulse → W_CHK. Then on `eot_i` → DONE.
  - DONE: `eos_o` = 1 for one cycle → IDLE.
- Checksum: XOR of every transmitted byte after the header, updated in the TX_MSB/TX_LSB cycles.
- Latency: `st_o` for the header asserts exactly 1 cycle after the trigger cycle. Each `strc_o`/`st_o` asserts 1 cycle after the preceding `eoc_i`/`eot_i` (NEXT_CH adds one cycle per index stepped).
- `eoc_i`/`eot_i` outside their wait state are ignored. No timeout; the block waits indefinitely.
- Empty mask: frame is HDR, 8'h00; no SPI activity.
- Channel index counter is `$clog2(NUM_CH+1)` bits wide. Bits of ch[3:0]/ch[2:0] above the counter width are zero.

Decomposition:
- Package `adc_scan_pkg`: state enum, frame header default, command-byte field positions (START bit 7, ADDR 6:4).
- Optional sub-module `scan_period_timer` (counter, clear, saturate, compare). The FSM and frame formatter stay in the top.

Test Plan:
- NUM_CH = 4, `ch_en_i` = 4'b0101, single start, ADC model returns 12'hABC (ch0) and 12'h123 (ch2):
  - `cmd_o` sequence 8'h87, 8'hA7.
  - Bytes A5, 0A, BC, 21, 23, B4.
  - One `eos_o` pulse.
- `ch_en_i` = 0, single start → bytes A5, 00; zero `strc_o` pulses; `eos_o` after second `eot_i`.
- `start_i` pulsed during W_CONV → frame unchanged, `ovr_o` = 1 and stays 1 until reset.
- `mode_i` = 1, `period_i` = 999, fast BFMs (scan < 1000 cycles) → header `st_o` edges exactly 1000 cycles apart. With `period_i` = 10 → scans back-to-back, IDLE for one cycle between them.
- `ch_en_i` changed from 4'b0001 to 4'b1111 mid-scan → current frame holds one channel; next frame holds four.
- `rst_i` low during W_LSB → all outputs 0 immediately. After release, no `st_o` until a new trigger; next frame starts with A5.
